// File: rtl/reduce_arbiter.sv
// reduce_arbiter
//   Shares one 4-bit AND/OR reduction unit between NREQ requesters. A
//   round-robin arbiter picks a request in IDLE, the operand and requester
//   index are latched, CALC registers the reductions, and DONE presents the
//   tagged result on a valid/ready response port.
//
// Optional feature: define REDUCE_ARB_XOR_EN to add the rsp_xor port and the
// parity reduction. Without it there is no parity port or logic.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   req[NREQ]     per-requester request, held with its operand until granted
//   data[4*NREQ]  operands, requester i uses data[4*i +: 4]
//   gnt[NREQ]     one-hot pulse: operand accepted this cycle (IDLE only)
//   busy          FSM is not IDLE
//   rsp_valid / rsp_ready / rsp_id / rsp_and / rsp_or [/ rsp_xor]
//                 response channel
//   dbg_state     current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: a response transfers on a cycle where rsp_valid && rsp_ready.
// rsp_valid and all rsp_* payload bits hold steady until that cycle, and
// rsp_ready is ignored whenever rsp_valid is low.
module reduce_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_and,
  output logic              rsp_or,
`ifdef REDUCE_ARB_XOR_EN
  output logic              rsp_xor,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [3:0]     op_q;

  logic           any_req;
  logic           hi_found;
  logic [IDW-1:0] hi_id;
  logic [IDW-1:0] lo_id;
  logic [IDW-1:0] pick;
  logic [3:0]     op_sel;

  // Round-robin search. Scanning downward means the last hit in each half is
  // the lowest index: hi_id is the first request at or above ptr, lo_id the
  // first below it (the wrap-around candidate).
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end else begin
          lo_id = IDW'(i);
        end
      end
    end
    any_req = |req;
    pick    = hi_found ? hi_id : lo_id;
  end

  // Operand mux and one-hot grant. The grant is also masked by rst_n so that
  // gnt reads 0 while reset is held even if requests are present.
  always_comb begin
    op_sel = 4'h0;
    gnt    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDW'(i)) begin
        op_sel = data[4*i +: 4];
        gnt[i] = (state == IDLE) && any_req && rst_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      op_q      <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_and   <= 1'b0;
      rsp_or    <= 1'b0;
`ifdef REDUCE_ARB_XOR_EN
      rsp_xor   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_q  <= op_sel;
            id_q  <= pick;
            // Explicit wrap keeps ptr inside 0..NREQ-1 for any NREQ.
            ptr   <= (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          rsp_id    <= id_q;
          rsp_and   <= &op_q;
          rsp_or    <= |op_q;
`ifdef REDUCE_ARB_XOR_EN
          rsp_xor   <= ^op_q;
`endif
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Payload registers are left alone; only valid drops on transfer.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
